regfile_dump_reader: RTL and testbench

Sequential read-side master for the single-cycle core's 32×32 register file. On a start pulse it walks the register file's combinational read port from FIRST_REG to LAST_REG and streams each (index, value) pair over a valid/ready output channel. The channel feeds the debug/trace path and testbench dump logic. It uses one spare read port and never writes the register file.

---
 rtl/regfile_dbg_pkg.sv | 15 +
 rtl/regfile_dump_reader.sv | 106 ++++++++++
 tb/tb_regfile_dump_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug/trace path.
// Holds the dump FSM state type and the register file geometry.
package regfile_dbg_pkg;

    localparam int REG_COUNT      = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file read port from FIRST_REG to LAST_REG and streams
// each (index, value) pair over a valid/ready channel, one beat per two cycles.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = REG_COUNT - 1,
    parameter int ADDR_W    = REGFILE_ADDR_W,
    parameter int DATA_W    = REGFILE_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_rf_addr,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_index,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_last
);

    localparam logic [ADDR_W-1:0] L_FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(LAST_REG);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [ADDR_W-1:0] r_out_index;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state <= S_FETCH;
                        r_idx   <= L_FIRST;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_out_data  <= i_rf_data;
                        r_out_index <= r_idx;
                        r_out_last  <= (r_idx == L_LAST);
                        r_valid     <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Abort wins over a handshake landing on the same edge.
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (i_out_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == L_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // The read address is the index register itself, so it holds in IDLE.
    assign o_rf_addr   = r_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_out_valid = r_valid;
    assign o_out_index = r_out_index;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader: a full-range and a
// short-range instance share one register file array and a beat-list model.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rf [32];

    logic        start0 = 0, abort0 = 0, ready0 = 1;
    logic        busy0, done0, valid0, last0;
    logic [4:0]  addr0, idx0;
    logic [31:0] rdata0, data0;

    logic        start1 = 0, abort1 = 0, ready1 = 1;
    logic        busy1, done1, valid1, last1;
    logic [4:0]  addr1, idx1;
    logic [31:0] rdata1, data1;

    assign rdata0 = rf[addr0];
    assign rdata1 = rf[addr1];

    always #5 clk = ~clk;

    regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start0), .i_abort(abort0),
        .o_busy(busy0), .o_done(done0), .o_rf_addr(addr0), .i_rf_data(rdata0),
        .o_out_valid(valid0), .i_out_ready(ready0), .o_out_index(idx0),
        .o_out_data(data0), .o_out_last(last0));

    regfile_dump_reader #(.FIRST_REG(1), .LAST_REG(3)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start1), .i_abort(abort1),
        .o_busy(busy1), .o_done(done1), .o_rf_addr(addr1), .i_rf_data(rdata1),
        .o_out_valid(valid1), .i_out_ready(ready1), .o_out_index(idx1),
        .o_out_data(data1), .o_out_last(last1));

    int total = 0;
    int bad = 0;

    logic [4:0]  got_idx[$], exp_idx[$];
    logic [31:0] got_data[$], exp_data[$];
    logic        got_last[$], exp_last[$];
    int done_at, done_cnt, stab_err, busy_err;
    logic post_valid, post_busy, post_done, post_last;
    logic [4:0]  post_idx, post_addr;
    logic [31:0] post_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat list: registers lo..hi taken straight from the array.
    task automatic build_model(input int lo, input int hi, input int last_reg);
        exp_idx.delete(); exp_data.delete(); exp_last.delete();
        for (int i = lo; i <= hi; i++) begin
            exp_idx.push_back(5'(i));
            exp_data.push_back(rf[i]);
            exp_last.push_back(i == last_reg);
        end
    endtask

    // mode 0: ready high, 1: 3-cycle stall at index p, 2: abort at index p,
    // 3: random ready, 4: reset pulse at index p
    task automatic run0(input int mode, input int p, input int budget);
        int j, stall_left;
        bit stalled, fired, hold, post_now;
        logic [4:0] h_idx;
        logic [31:0] h_data;
        logic h_last;
        got_idx.delete(); got_data.delete(); got_last.delete();
        done_at = -1; done_cnt = 0; stab_err = 0; busy_err = 0;
        stall_left = 0; stalled = 0; fired = 0;
        ready0 = 1; start0 = 1; tick(); start0 = 0; j = 0;
        while (j < budget && !(done_at >= 0 && j >= done_at + 3)) begin
            ready0 = 1; abort0 = 0;
            if (mode == 3) ready0 = 1'($urandom_range(0, 1));
            if (mode == 1 && valid0 && idx0 == 5'(p) && !stalled) begin
                stalled = 1; stall_left = 3;
            end
            if (stall_left > 0) begin ready0 = 0; stall_left--; end
            if ((mode == 2 || mode == 4) && valid0 && idx0 == 5'(p) && !fired) begin
                fired = 1;
                if (mode == 2) abort0 = 1; else rst_n = 0;
            end
            if (valid0 && ready0 && !abort0 && rst_n) begin
                got_idx.push_back(idx0); got_data.push_back(data0); got_last.push_back(last0);
            end
            hold = valid0 && !ready0;
            h_idx = idx0; h_data = data0; h_last = last0;
            tick(); j++;
            post_now = abort0 || !rst_n;
            abort0 = 0; rst_n = 1;
            if (post_now) begin
                post_valid = valid0; post_busy = busy0; post_done = done0; post_last = last0;
                post_idx = idx0; post_data = data0; post_addr = addr0;
            end
            if (hold && (!valid0 || idx0 !== h_idx || data0 !== h_data || last0 !== h_last))
                stab_err++;
            if (done0) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
                if (busy0) busy_err++;
            end
        end
    endtask

    task automatic test_reset();
        total++; if ({busy0, done0, valid0, last0} !== 4'b0) begin bad++;
            $display("FAIL reset_flags got %b want 0000", {busy0, done0, valid0, last0}); end
        total++; if ({idx0, addr0} !== 10'b0) begin bad++;
            $display("FAIL reset_index got %0d/%0d want 0/0", idx0, addr0); end
        total++; if (data0 !== 32'h0) begin bad++;
            $display("FAIL reset_data got %h want 0", data0); end
        start0 = 1; abort0 = 1; tick(); start0 = 0; abort0 = 0;
        total++; if (busy0 !== 1'b0 || valid0 !== 1'b0) begin bad++;
            $display("FAIL idle_start_abort got busy=%b valid=%b want 0/0", busy0, valid0); end
    endtask

    task automatic test_full_dump();
        int errs = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1;
        build_model(0, 31, 31);
        run0(0, 0, 200);
        total++; if (got_idx.size() != 32) begin bad++;
            $display("FAIL full_count got %0d want 32", got_idx.size()); end
        for (int i = 0; i < 32 && i < got_idx.size(); i++)
            if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) errs++;
        total++; if (errs != 0) begin bad++;
            $display("FAIL full_beats got %0d bad beats want 0", errs); end
        total++; if (done_at != 64) begin bad++;
            $display("FAIL full_done_at got %0d want 64", done_at); end
        total++; if (done_cnt != 1 || busy_err != 0) begin bad++;
            $display("FAIL full_done_pulse got cnt=%0d busyerr=%0d want 1/0", done_cnt, busy_err); end
    endtask

    task automatic test_preload();
        int errs = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[5] = 32'hDEADBEEF; rf[31] = 32'h0000_00FF;
        build_model(0, 31, 31);
        run0(0, 0, 200);
        total++; if (got_idx.size() != 32) begin bad++;
            $display("FAIL preload_count got %0d want 32", got_idx.size()); end
        else begin
            total++; if (got_data[5] !== 32'hDEADBEEF) begin bad++;
                $display("FAIL preload_x5 got %h want deadbeef", got_data[5]); end
            total++; if (got_data[31] !== 32'hFF || got_last[31] !== 1'b1) begin bad++;
                $display("FAIL preload_x31 got %h/%b want ff/1", got_data[31], got_last[31]); end
            for (int i = 0; i < 32; i++)
                if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) errs++;
            total++; if (errs != 0) begin bad++;
                $display("FAIL preload_beats got %0d bad beats want 0", errs); end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run0(1, 7, 200);
        total++; if (stab_err != 0) begin bad++;
            $display("FAIL bp_stable got %0d unstable cycles want 0", stab_err); end
        total++; if (got_idx.size() != 32) begin bad++;
            $display("FAIL bp_count got %0d want 32", got_idx.size()); end
        total++; if (done_at != 67) begin bad++;
            $display("FAIL bp_done_at got %0d want 67", done_at); end
    endtask

    task automatic test_abort();
        int errs = 0;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        build_model(0, 9, 31);
        run0(2, 10, 60);
        total++; if (got_idx.size() != 10) begin bad++;
            $display("FAIL abort_count got %0d want 10", got_idx.size()); end
        for (int i = 0; i < 10 && i < got_idx.size(); i++)
            if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i]) errs++;
        total++; if (errs != 0) begin bad++;
            $display("FAIL abort_beats got %0d bad beats want 0", errs); end
        total++; if (post_valid !== 1'b0 || post_busy !== 1'b0 || post_done !== 1'b0) begin bad++;
            $display("FAIL abort_after got v=%b b=%b d=%b want 0/0/0", post_valid, post_busy, post_done); end
        total++; if (done_cnt != 0 || busy0 !== 1'b0) begin bad++;
            $display("FAIL abort_no_done got cnt=%0d busy=%b want 0/0", done_cnt, busy0); end
    endtask

    task automatic test_short_range();
        int j = 0, dat = -1, dcnt = 0, errs = 0, nb = 0;
        for (int i = 1; i <= 3; i++) rf[i] = $urandom;
        build_model(1, 3, 3);
        ready1 = 1; start1 = 1; tick(); start1 = 0;
        while (j < 40) begin
            if (j == 2) start1 = 1;
            if (valid1 && ready1) begin
                if (nb >= 3 || idx1 !== exp_idx[nb] || data1 !== exp_data[nb] || last1 !== exp_last[nb]) errs++;
                nb++;
            end
            tick(); j++; start1 = 0;
            if (done1) begin dcnt++; if (dat < 0) dat = j; end
            if (dat >= 0 && j >= dat + 4) break;
        end
        total++; if (nb != 3 || errs != 0) begin bad++;
            $display("FAIL short_beats got n=%0d err=%0d want 3/0", nb, errs); end
        total++; if (dat != 6 || dcnt != 1) begin bad++;
            $display("FAIL short_done got at=%0d cnt=%0d want 6/1", dat, dcnt); end
        total++; if (busy1 !== 1'b0) begin bad++;
            $display("FAIL short_restart got busy=%b want 0", busy1); end
    endtask

    task automatic test_back_to_back();
        int j = 0;
        ready1 = 1; start1 = 1; tick(); start1 = 0;
        while (!done1 && j < 20) begin tick(); j++; end
        total++; if (done1 !== 1'b1) begin bad++;
            $display("FAIL b2b_first_done got %b want 1", done1); end
        start1 = 1; tick(); start1 = 0;
        total++; if (busy1 !== 1'b1) begin bad++;
            $display("FAIL b2b_accept got busy=%b want 1", busy1); end
        j = 0;
        while (!done1 && j < 20) begin tick(); j++; end
        total++; if (done1 !== 1'b1) begin bad++;
            $display("FAIL b2b_second_done got %b want 1", done1); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        run0(4, 20, 60);
        total++; if ({post_valid, post_busy, post_done, post_last} !== 4'b0) begin bad++;
            $display("FAIL rstmid_flags got %b want 0000", {post_valid, post_busy, post_done, post_last}); end
        total++; if (post_idx !== 5'd0 || post_addr !== 5'd0 || post_data !== 32'h0) begin bad++;
            $display("FAIL rstmid_regs got %0d/%0d/%h want 0/0/0", post_idx, post_addr, post_data); end
        total++; if (done_cnt != 0 || got_idx.size() != 20) begin bad++;
            $display("FAIL rstmid_silent got done=%0d beats=%0d want 0/20", done_cnt, got_idx.size()); end
        run0(0, 0, 200);
        total++; if (got_idx.size() != 32 || got_idx[0] !== 5'd0) begin bad++;
            $display("FAIL rstmid_restart got n=%0d want 32 from index 0", got_idx.size()); end
    endtask

    task automatic test_random_ready();
        for (int r = 0; r < 3; r++) begin
            int errs = 0;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            build_model(0, 31, 31);
            run0(3, 0, 600);
            total++; if (got_idx.size() != 32 || done_cnt != 1) begin bad++;
                $display("FAIL rand_count got n=%0d done=%0d want 32/1", got_idx.size(), done_cnt); end
            for (int i = 0; i < 32 && i < got_idx.size(); i++)
                if (got_idx[i] !== exp_idx[i] || got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) errs++;
            total++; if (errs != 0 || stab_err != 0) begin bad++;
                $display("FAIL rand_beats got err=%0d unstable=%0d want 0/0", errs, stab_err); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n = 0; tick(); tick(); rst_n = 1;
        test_reset();
        test_full_dump();
        test_preload();
        test_backpressure();
        test_abort();
        test_short_range();
        test_back_to_back();
        test_reset_mid();
        test_random_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
